// File: rtl/fir_coef_sched.sv
// fir_coef_sched: double-buffered coefficient scheduler for the folded 15-tap FIR.
// Host writes land in a shadow bank; a commit arms a swap that copies the shadow
// bank into the active bank (coef_bus) on the next sample strobe, so a coefficient
// update never tears a sample.
// Optional feature: define FIR_COEF_FLUSH_EN to add a FLUSH state that holds
// filt_flush high for FLUSH_LEN sample strobes after every swap.
//
// Handshake: a write transfers on a rising sys_clk edge where wr_valid && wr_ready;
// wr_ready is registered and low outside IDLE, and a write offered while it is low
// is neither stored nor flagged (the host retries).
module fir_coef_sched #(
  parameter int WIDTH     = 18,
  parameter int NCOEF     = 8,
  parameter int AW        = 3,
  parameter int FLUSH_LEN = 15
) (
  input  logic                   sys_clk,
  input  logic                   reset,
  input  logic                   sam_clk_en,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic [AW-1:0]          wr_addr,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   commit,
  input  logic                   err_clr,
  output logic [NCOEF*WIDTH-1:0] coef_bus,
  output logic                   filt_flush,
  output logic                   busy,
  output logic                   swap_done,
  output logic                   bank_id,
  output logic [1:0]             err,
  output logic [1:0]             state_dbg
);

`ifdef FIR_COEF_FLUSH_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ARMED = 2'd1, S_FLUSH = 2'd2} state_t;
  localparam int CW = $clog2(FLUSH_LEN + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          flush_q;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ARMED = 2'd1} state_t;
`endif

  state_t                   state_q, state_d;
  logic [NCOEF*WIDTH-1:0]   shadow_q, shadow_d;
  logic [NCOEF*WIDTH-1:0]   active_q, active_d;
  logic                     bank_q, bank_d;
  logic                     swap_q, swap_d;
  logic [1:0]               err_q, err_d;
  logic                     wr_ready_q, busy_q;

  // Next-state, bank updates and sticky error bits; a new error beats err_clr.
  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    active_d = active_q;
    bank_d   = bank_q;
    swap_d   = 1'b0;
    err_d    = err_clr ? 2'b00 : err_q;
`ifdef FIR_COEF_FLUSH_EN
    cnt_d    = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (wr_valid) begin
          if (int'(wr_addr) < NCOEF) begin
            for (int i = 0; i < NCOEF; i++) begin
              if (wr_addr == AW'(i)) shadow_d[i*WIDTH +: WIDTH] = wr_data;
            end
          end else begin
            err_d[0] = 1'b1;
          end
        end
        // The strobe of this same cycle is deliberately not used for the swap.
        if (commit) state_d = S_ARMED;
      end
      S_ARMED: begin
        if (commit) err_d[1] = 1'b1;
        if (sam_clk_en) begin
          active_d = shadow_q;
          bank_d   = ~bank_q;
          swap_d   = 1'b1;
`ifdef FIR_COEF_FLUSH_EN
          state_d  = S_FLUSH;
          cnt_d    = '0;
`else
          state_d  = S_IDLE;
`endif
        end
      end
`ifdef FIR_COEF_FLUSH_EN
      S_FLUSH: begin
        if (commit) err_d[1] = 1'b1;
        if (sam_clk_en) begin
          if (cnt_q == CW'(FLUSH_LEN - 1)) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // State and bank registers; status outputs are registered from the next state.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      shadow_q   <= '0;
      active_q   <= '0;
      bank_q     <= 1'b0;
      swap_q     <= 1'b0;
      err_q      <= 2'b00;
      wr_ready_q <= 1'b1;
      busy_q     <= 1'b0;
`ifdef FIR_COEF_FLUSH_EN
      cnt_q      <= '0;
      flush_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      shadow_q   <= shadow_d;
      active_q   <= active_d;
      bank_q     <= bank_d;
      swap_q     <= swap_d;
      err_q      <= err_d;
      wr_ready_q <= (state_d == S_IDLE);
      busy_q     <= (state_d != S_IDLE);
`ifdef FIR_COEF_FLUSH_EN
      cnt_q      <= cnt_d;
      flush_q    <= (state_d == S_FLUSH);
`endif
    end
  end

  assign coef_bus  = active_q;
  assign wr_ready  = wr_ready_q;
  assign busy      = busy_q;
  assign swap_done = swap_q;
  assign bank_id   = bank_q;
  assign err       = err_q;
  assign state_dbg = state_q;
`ifdef FIR_COEF_FLUSH_EN
  assign filt_flush = flush_q;
`else
  assign filt_flush = 1'b0;
`endif

endmodule

// File: tb/tb_fir_coef_sched.sv
// Bench for fir_coef_sched: directed host traffic, with swap results checked by a
// monitor against an expected queue filled when each commit is issued.
module tb_fir_coef_sched;
  localparam int WIDTH     = 18;
  localparam int NCOEF     = 8;
  localparam int AW        = 3;
  localparam int FLUSH_LEN = 15;
  localparam int BW        = NCOEF * WIDTH;

  logic             sys_clk = 1'b0;
  logic             reset = 1'b1;
  logic             sam_clk_en = 1'b0;
  logic             wr_valid = 1'b0;
  logic             wr_ready;
  logic [AW-1:0]    wr_addr = '0;
  logic [WIDTH-1:0] wr_data = '0;
  logic             commit = 1'b0;
  logic             err_clr = 1'b0;
  logic [BW-1:0]    coef_bus;
  logic             filt_flush;
  logic             busy;
  logic             swap_done;
  logic             bank_id;
  logic [1:0]       err;
  logic [1:0]       state_dbg;

  fir_coef_sched #(.WIDTH(WIDTH), .NCOEF(NCOEF), .AW(AW), .FLUSH_LEN(FLUSH_LEN)) dut (
    .sys_clk(sys_clk), .reset(reset), .sam_clk_en(sam_clk_en),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .commit(commit), .err_clr(err_clr), .coef_bus(coef_bus), .filt_flush(filt_flush),
    .busy(busy), .swap_done(swap_done), .bank_id(bank_id), .err(err),
    .state_dbg(state_dbg)
  );

  // Clock and reset
  always #5 sys_clk = ~sys_clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Scoreboard state
  logic [BW-1:0] exp_q[$];
  logic          exp_bank_q[$];
  logic [BW-1:0] model = '0;
  logic          bank_exp = 1'b0;
  logic [BW-1:0] prev_coef = '0;

  task automatic chk(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: each swap_done pulse pops one expected bank; coef_bus may not move otherwise.
  always @(negedge sys_clk) begin
    if (reset) begin
      prev_coef = '0;
    end else begin
      if (swap_done) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_swap: got swap_done=1 expected no pending commit");
        end else begin
          logic [BW-1:0] e;
          logic          eb;
          e  = exp_q.pop_front();
          eb = exp_bank_q.pop_front();
          chk("swap_coef_bus", coef_bus, e);
          chk("swap_bank_id", BW'(bank_id), BW'(eb));
        end
      end else if (coef_bus !== prev_coef) begin
        chk("coef_bus_stable", coef_bus, prev_coef);
      end
      prev_coef = coef_bus;
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic set_model(input int idx, input int val);
    logic [31:0] v;
    v = val;
    model[idx*WIDTH +: WIDTH] = v[WIDTH-1:0];
  endtask

  task automatic host_write(input int idx, input int val);
    logic [31:0] v;
    v = val;
    wr_valid = 1'b1;
    wr_addr  = AW'(idx);
    wr_data  = v[WIDTH-1:0];
    tick();
    wr_valid = 1'b0;
    set_model(idx, val);
  endtask

  task automatic push_swap();
    bank_exp = ~bank_exp;
    exp_q.push_back(model);
    exp_bank_q.push_back(bank_exp);
  endtask

  task automatic strobe();
    repeat (3) tick();
    sam_clk_en = 1'b1;
    tick();
    sam_clk_en = 1'b0;
  endtask

  task automatic do_commit();
    commit = 1'b1;
    tick();
    commit = 1'b0;
  endtask

  task automatic check_idle_status(input string nm);
    chk({nm, "_busy"}, BW'(busy), BW'(0));
    chk({nm, "_wr_ready"}, BW'(wr_ready), BW'(1));
    chk({nm, "_filt_flush"}, BW'(filt_flush), BW'(0));
  endtask

  // Called right after the swap strobe: checks the flush window, then leaves it.
  task automatic after_swap(input string nm);
`ifdef FIR_COEF_FLUSH_EN
    for (int k = 0; k < FLUSH_LEN; k++) begin
      chk({nm, "_flush_hi"}, BW'(filt_flush), BW'(1));
      chk({nm, "_flush_wr_ready"}, BW'(wr_ready), BW'(0));
      wr_valid = 1'b1;
      wr_addr  = AW'(1);
      wr_data  = 18'd777;
      strobe();
      wr_valid = 1'b0;
    end
    chk({nm, "_flush_err"}, BW'(err), BW'(0));
`endif
    check_idle_status(nm);
  endtask

  initial begin
    int v0[8];
    v0 = '{-322, 0, 3144, 0, -15695, 0, 78408, 131071};

    // Reset values while reset is held
    repeat (2) @(negedge sys_clk);
    chk("rst_coef_bus", coef_bus, '0);
    chk("rst_swap_done", BW'(swap_done), BW'(0));
    chk("rst_bank_id", BW'(bank_id), BW'(0));
    chk("rst_err", BW'(err), BW'(0));
    check_idle_status("rst");
    tick();
    reset = 1'b0;
    tick();

    // Load the full shadow bank; coef_bus must not follow
    for (int i = 0; i < NCOEF; i++) host_write(i, v0[i]);
    chk("wr_ready_after_writes", BW'(wr_ready), BW'(1));
    strobe();
    chk("no_swap_without_commit", coef_bus, '0);

    // Commit, idle a while, then swap on the next strobe
    do_commit();
    chk("armed_busy", BW'(busy), BW'(1));
    chk("armed_wr_ready", BW'(wr_ready), BW'(0));
    repeat (5) tick();
    chk("armed_coef_hold", coef_bus, '0);
    push_swap();
    strobe();
    after_swap("swap1");

    // Write with commit and a strobe in the same cycle: that strobe must not swap
    wr_valid = 1'b1; wr_addr = 3'd3; wr_data = 18'd500;
    commit = 1'b1; sam_clk_en = 1'b1;
    tick();
    wr_valid = 1'b0; commit = 1'b0; sam_clk_en = 1'b0;
    set_model(3, 500);
    chk("same_cycle_strobe_still_busy", BW'(busy), BW'(1));
    push_swap();
    strobe();
    after_swap("swap2");

    // Errors while armed: late commit flags, blocked write is silent
    do_commit();
    chk("err_clean_on_commit", BW'(err), BW'(0));
    wr_valid = 1'b1; wr_addr = 3'd7; wr_data = 18'd9999; commit = 1'b1;
    tick();
    wr_valid = 1'b0; commit = 1'b0;
    chk("err_commit_dropped", BW'(err), BW'(2'b10));
    commit = 1'b1; err_clr = 1'b1;
    tick();
    commit = 1'b0;
    chk("err_new_beats_clr", BW'(err), BW'(2'b10));
    tick();
    err_clr = 1'b0;
    chk("err_cleared", BW'(err), BW'(0));
    push_swap();
    strobe();
    after_swap("swap3");

    // Back-to-back commits, second one with a write in the first idle cycle
    host_write(2, -7);
    do_commit();
    push_swap();
    strobe();
    after_swap("b2b_a");
    wr_valid = 1'b1; wr_addr = 3'd4; wr_data = 18'd12345; commit = 1'b1;
    tick();
    wr_valid = 1'b0; commit = 1'b0;
    set_model(4, 12345);
    chk("b2b_second_armed", BW'(busy), BW'(1));
    push_swap();
    strobe();
    after_swap("b2b_b");

    // Reset in the middle of a pending commit (or flush)
    do_commit();
`ifdef FIR_COEF_FLUSH_EN
    push_swap();
    strobe();
    strobe();
    chk("mid_flush_high", BW'(filt_flush), BW'(1));
`endif
    #2 reset = 1'b1;
    #1;
    chk("async_rst_coef_bus", coef_bus, '0);
    chk("async_rst_bank_id", BW'(bank_id), BW'(0));
    check_idle_status("async_rst");
    tick();
    reset = 1'b0;
    model = '0;
    bank_exp = 1'b0;
    tick();
    host_write(0, 1234);
    do_commit();
    push_swap();
    strobe();
    after_swap("post_rst");
    chk("post_rst_coef_bus", coef_bus, model);

    repeat (4) tick();
    chk("all_swaps_seen", BW'(exp_q.size()), BW'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Hard stop in case something above stalls
  initial begin
    #200000;
    $display("FAIL timeout: got no end of test expected finish before 200000");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
